// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared fetch constants, state encodings and jump-target helper
package if_stage_pkg;

  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  // Fetch state encodings kept as plain constants so older decoder code can share them.
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Opcode/funct values the decoder uses to raise id_jump / id_jr.
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] FUNCT_JR  = 6'h08;

  // jr takes the forwarded register; j/jal splice the 26-bit field into the pc+4 region.
  function automatic logic [31:0] jump_target(
    input logic        is_jr,
    input logic [31:0] rs_value,
    input logic [31:0] pc_plus4,
    input logic [25:0] target
  );
    if (is_jr) begin
      return rs_value;
    end
    return {pc_plus4[31:28], target, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID pipeline register with load, hold and flush
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  // Flush beats load; with neither the register holds its contents.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else if (load_i) begin
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - fetch stage: PC, redirects, halt drain; IF_PERF_COUNT_EN adds perf counters
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_AW      = 9,
  parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               id_jump,
  input  logic               id_jr,
  input  logic [25:0]        id_target,
  input  logic [31:0]        id_rs_value,
  input  logic               ex_branch_taken,
  input  logic [31:0]        ex_branch_pc,
  output logic [31:0]        id_instruction,
  output logic [31:0]        id_pc_plus4,
  output logic               id_valid,
  output logic               halted
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall_cycles
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic        reg_load, reg_flush;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign halted    = (state_q == ST_HALTED);

  // Next-PC selection and fetch state machine; redirects outrank stall, stall outranks jump and halt.
  always_comb begin
    pc_d        = pc_q;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    reg_load    = 1'b0;
    reg_flush   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          pc_d      = ex_branch_pc;
          reg_flush = 1'b1;
        end else if (stall) begin
          // Hold everything; a pending jr operand may not be forwarded yet.
        end else if (id_jump) begin
          pc_d      = jump_target(id_jr, id_rs_value, id_pc_plus4, id_target);
          reg_flush = 1'b1;
        end else if (imem_rdata == HALT_WORD) begin
          reg_flush   = 1'b1;
          state_d     = ST_DRAIN;
          drain_cnt_d = 8'd0;
        end else begin
          pc_d     = pc_plus4;
          reg_load = 1'b1;
        end
      end
      ST_DRAIN: begin
        reg_flush = 1'b1;
        if (ex_branch_taken) begin
          pc_d        = ex_branch_pc;
          state_d     = ST_RUN;
          drain_cnt_d = 8'd0;
        end else if (!stall) begin
          drain_cnt_d = drain_cnt_q + 8'd1;
          if (drain_cnt_d >= 8'(DRAIN_CYCLES - 1)) begin
            state_d = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        reg_flush = 1'b1;
      end
      default: begin
        reg_flush = 1'b1;
        state_d   = ST_RUN;
      end
    endcase
  end

  // PC, state and drain counter registers; reset is a full restart from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      state_q     <= ST_RUN;
      drain_cnt_q <= 8'd0;
    end else begin
      pc_q        <= pc_d;
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (reg_load),
    .flush_i    (reg_flush),
    .instr_i    (imem_rdata),
    .pc_plus4_i (pc_plus4),
    .instr_o    (id_instruction),
    .pc_plus4_o (id_pc_plus4),
    .valid_o    (id_valid)
  );

`ifdef IF_PERF_COUNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  // Fetch and stall-cycle counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      if (reg_load) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if ((state_q == ST_RUN) && stall && !ex_branch_taken) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed vector bench for the fetch stage and IF/ID register
module tb_if_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        stall, id_jump, id_jr, ex_branch_taken;
  logic [25:0] id_target;
  logic [31:0] id_rs_value, ex_branch_pc;
  logic [31:0] id_instruction, id_pc_plus4;
  logic        id_valid, halted;
`ifdef IF_PERF_COUNT_EN
  logic [31:0] perf_fetched, perf_stall_cycles;
`endif

  logic [31:0] mem [512];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .id_jump         (id_jump),
    .id_jr           (id_jr),
    .id_target       (id_target),
    .id_rs_value     (id_rs_value),
    .ex_branch_taken (ex_branch_taken),
    .ex_branch_pc    (ex_branch_pc),
    .id_instruction  (id_instruction),
    .id_pc_plus4     (id_pc_plus4),
    .id_valid        (id_valid),
    .halted          (halted)
`ifdef IF_PERF_COUNT_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  typedef struct {
    logic        s, j, jr;
    logic [25:0] t;
    logic [31:0] rs;
    logic        b;
    logic [31:0] bp;
    logic [31:0] e_instr, e_pc4;
    logic        e_valid;
    logic [8:0]  e_addr;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mkv(logic s, logic j, logic jr, logic [25:0] t, logic [31:0] rs,
                               logic b, logic [31:0] bp, logic [31:0] ei, logic [31:0] ep,
                               logic ev, logic [8:0] ea);
    vec_t v;
    v.s = s; v.j = j; v.jr = jr; v.t = t; v.rs = rs; v.b = b; v.bp = bp;
    v.e_instr = ei; v.e_pc4 = ep; v.e_valid = ev; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic j, input logic jr, input logic [25:0] t,
                      input logic [31:0] rs, input logic b, input logic [31:0] bp);
    stall = s; id_jump = j; id_jr = jr; id_target = t; id_rs_value = rs;
    ex_branch_taken = b; ex_branch_pc = bp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 26'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    mem[4] = HALT;

    //           s  j  jr t        rs           b  bp            instr         pc4           v  addr
    vecs[0]  = mkv(0, 0, 0, 26'h0,   32'h0,       0, 32'h0,        32'h2008_0001, 32'h4,        1, 9'd1);
    vecs[1]  = mkv(0, 0, 0, 26'h0,   32'h0,       0, 32'h0,        32'h2009_0002, 32'h8,        1, 9'd2);
    vecs[2]  = mkv(1, 0, 0, 26'h0,   32'h0,       0, 32'h0,        32'h2009_0002, 32'h8,        1, 9'd2);
    vecs[3]  = mkv(1, 0, 0, 26'h0,   32'h0,       0, 32'h0,        32'h2009_0002, 32'h8,        1, 9'd2);
    vecs[4]  = mkv(0, 0, 0, 26'h0,   32'h0,       0, 32'h0,        32'h0109_5020, 32'hC,        1, 9'd3);
    vecs[5]  = mkv(0, 1, 0, 26'h10,  32'h0,       0, 32'h0,        32'h0,         32'h0,        0, 9'd16);
    vecs[6]  = mkv(0, 0, 0, 26'h0,   32'h0,       0, 32'h0,        32'h1000_0010, 32'h44,       1, 9'd17);
    vecs[7]  = mkv(1, 1, 0, 26'h3,   32'h0,       1, 32'h80,       32'h0,         32'h0,        0, 9'd32);
    vecs[8]  = mkv(0, 0, 0, 26'h0,   32'h0,       0, 32'h0,        32'h1000_0020, 32'h84,       1, 9'd33);
    vecs[9]  = mkv(0, 1, 1, 26'h3FF, 32'hC,       0, 32'h0,        32'h0,         32'h0,        0, 9'd3);
    vecs[10] = mkv(0, 0, 0, 26'h0,   32'h0,       0, 32'h0,        32'h1000_0003, 32'h10,       1, 9'd4);
    vecs[11] = mkv(1, 1, 0, 26'h5,   32'h0,       0, 32'h0,        32'h1000_0003, 32'h10,       1, 9'd4);
    vecs[12] = mkv(1, 0, 0, 26'h0,   32'h0,       0, 32'h0,        32'h1000_0003, 32'h10,       1, 9'd4);
    vecs[13] = mkv(0, 1, 0, 26'h8,   32'h0,       0, 32'h0,        32'h0,         32'h0,        0, 9'd8);
    vecs[14] = mkv(0, 0, 0, 26'h0,   32'h0,       0, 32'h0,        32'h1000_0008, 32'h24,       1, 9'd9);
    vecs[15] = mkv(0, 0, 0, 26'h0,   32'h0,       1, 32'hFFFF_FFFC, 32'h0,        32'h0,        0, 9'h1FF);
    vecs[16] = mkv(0, 0, 0, 26'h0,   32'h0,       0, 32'h0,        32'h1000_01FF, 32'h0,        1, 9'd0);
    vecs[17] = mkv(0, 0, 0, 26'h0,   32'h0,       1, 32'h10,       32'h0,         32'h0,        0, 9'd4);

    do_reset();
    chk("reset_instr", id_instruction, 32'h0);
    chk("reset_pc4", id_pc_plus4, 32'h0);
    chk("reset_valid", 32'(id_valid), 32'h0);
    chk("reset_addr", 32'(imem_addr), 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].s, vecs[i].j, vecs[i].jr, vecs[i].t, vecs[i].rs, vecs[i].b, vecs[i].bp);
      chk($sformatf("v%0d_instr", i), id_instruction, vecs[i].e_instr);
      chk($sformatf("v%0d_pc4", i), id_pc_plus4, vecs[i].e_pc4);
      chk($sformatf("v%0d_valid", i), 32'(id_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'h0);
    end

    // Halt at 0x10: halted rises after the third drain edge, then inputs are ignored.
    idle();
    chk("h_fetch_valid", 32'(id_valid), 32'h0);
    chk("h_fetch_instr", id_instruction, 32'h0);
    chk("h_fetch_addr", 32'(imem_addr), 32'd4);
    chk("h_fetch_halted", 32'(halted), 32'h0);
    idle();
    chk("h_d1_halted", 32'(halted), 32'h0);
    idle();
    chk("h_d2_halted", 32'(halted), 32'h0);
    idle();
    chk("h_d3_halted", 32'(halted), 32'h1);
    chk("h_d3_valid", 32'(id_valid), 32'h0);
    step(1'b0, 1'b1, 1'b0, 26'h8, 32'h0, 1'b1, 32'h80);
    chk("h_term_halted", 32'(halted), 32'h1);
    chk("h_term_addr", 32'(imem_addr), 32'd4);
    chk("h_term_valid", 32'(id_valid), 32'h0);
    do_reset();
    chk("h_rst_halted", 32'(halted), 32'h0);
    chk("h_rst_addr", 32'(imem_addr), 32'h0);

    // One stall during drain pushes halted out by one cycle.
    step(1'b0, 1'b0, 1'b0, 26'h0, 32'h0, 1'b1, 32'h10);
    chk("s_redirect_addr", 32'(imem_addr), 32'd4);
    idle();
    step(1'b1, 1'b0, 1'b0, 26'h0, 32'h0, 1'b0, 32'h0);
    chk("s_stall_halted", 32'(halted), 32'h0);
    idle();
    idle();
    chk("s_d3_halted", 32'(halted), 32'h0);
    idle();
    chk("s_d4_halted", 32'(halted), 32'h1);
    do_reset();

    // Branch during drain returns to RUN and fetch resumes at the target.
    step(1'b0, 1'b0, 1'b0, 26'h0, 32'h0, 1'b1, 32'h10);
    idle();
    chk("b_halt_valid", 32'(id_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 26'h0, 32'h0, 1'b1, 32'h20);
    chk("b_redirect_addr", 32'(imem_addr), 32'd8);
    chk("b_redirect_valid", 32'(id_valid), 32'h0);
    chk("b_redirect_halted", 32'(halted), 32'h0);
    idle();
    chk("b_resume_instr", id_instruction, 32'h1000_0008);
    chk("b_resume_pc4", id_pc_plus4, 32'h24);
    chk("b_resume_valid", 32'(id_valid), 32'h1);
    for (int k = 0; k < 4; k++) begin
      idle();
      chk($sformatf("b_run%0d_halted", k), 32'(halted), 32'h0);
      chk($sformatf("b_run%0d_pc4", k), id_pc_plus4, 32'h28 + 32'(4 * k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
